// File: rtl/hamming_dp_cmd_issuer_if.sv
// hamming_dp_cmd_issuer_if: command, dual memory port and response signals of the issuer
interface hamming_dp_cmd_issuer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_port;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              a_en;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_rdata;
    logic              b_en;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic [DATA_W-1:0] b_rdata;
    logic              rsp_valid;
    logic              rsp_port;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;
    logic              illegal_op;

    modport master (
        output cmd_valid, cmd_port, cmd_op, cmd_addr, cmd_wdata, a_rdata, b_rdata,
        input  cmd_ready, a_en, a_we, a_addr, a_wdata, b_en, b_we, b_addr, b_wdata,
        input  rsp_valid, rsp_port, rsp_data, busy, illegal_op
    );

    modport slave (
        input  cmd_valid, cmd_port, cmd_op, cmd_addr, cmd_wdata, a_rdata, b_rdata,
        output cmd_ready, a_en, a_we, a_addr, a_wdata, b_en, b_we, b_addr, b_wdata,
        output rsp_valid, rsp_port, rsp_data, busy, illegal_op
    );
endinterface

// File: rtl/hamming_dp_cmd_issuer.sv
// hamming_dp_cmd_issuer: FIFO-buffered command issuer driving both ports of the dual-port memory
module hamming_dp_cmd_issuer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int RD_LAT = 1
) (
    input logic clk,
    input logic rst_n,
    hamming_dp_cmd_issuer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = 3 + ADDR_W + DATA_W;
    localparam logic [1:0] OP_WR  = 2'd0;
    localparam logic [1:0] OP_RD  = 2'd1;
    localparam logic [1:0] OP_ILL = 2'd3;
    localparam logic [1:0] LAT    = 2'(RD_LAT);

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

    logic [EW-1:0]     fifo_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       count_q;
    logic              push, pop;
    logic              head_port;
    logic [1:0]        head_op;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;
    logic              illegal_q;

    state_t            state_q;
    logic              rd_q, port_q, rsp_valid_q;
    logic [1:0]        cnt_q;
    logic              a_en_q, a_we_q, b_en_q, b_we_q;
    logic [ADDR_W-1:0] a_addr_q, b_addr_q;
    logic [DATA_W-1:0] a_wdata_q, b_wdata_q;

    // A new head is popped whenever the FSM is free to issue: idle, after a non-read, or on the last read-wait cycle
    assign push = bus.cmd_valid && bus.cmd_ready;
    assign pop  = (count_q != '0) && (state_q == IDLE || (state_q == ISSUE && !rd_q) ||
                                      (state_q == RD_WAIT && cnt_q == 2'd1));
    assign {head_port, head_op, head_addr, head_wdata} = fifo_q[rd_ptr_q];

    assign bus.cmd_ready  = count_q != (PW+1)'(DEPTH);
    assign bus.busy       = (count_q != '0) || (state_q != IDLE);
    assign bus.illegal_op = illegal_q;
    assign bus.a_en       = a_en_q;
    assign bus.a_we       = a_we_q;
    assign bus.a_addr     = a_addr_q;
    assign bus.a_wdata    = a_wdata_q;
    assign bus.b_en       = b_en_q;
    assign bus.b_we       = b_we_q;
    assign bus.b_addr     = b_addr_q;
    assign bus.b_wdata    = b_wdata_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_port   = port_q;
    // Read data is only valid on the response cycle itself, so it is muxed straight through
    assign bus.rsp_data   = rsp_valid_q ? (port_q ? bus.b_rdata : bus.a_rdata) : '0;

    // Command storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= {bus.cmd_port, bus.cmd_op, bus.cmd_addr, bus.cmd_wdata};
    end

    // FIFO pointers, occupancy and the sticky illegal-op flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q   <= count_q + (PW+1)'(push) - (PW+1)'(pop);
            illegal_q <= illegal_q | (push && bus.cmd_op == OP_ILL);
        end
    end

    // Issue FSM: strobes are registered on the edge that pops, so they show during the ISSUE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_q        <= 1'b0;
            port_q      <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            a_en_q      <= 1'b0;
            a_we_q      <= 1'b0;
            a_addr_q    <= '0;
            a_wdata_q   <= '0;
            b_en_q      <= 1'b0;
            b_we_q      <= 1'b0;
            b_addr_q    <= '0;
            b_wdata_q   <= '0;
        end else begin
            a_en_q      <= 1'b0;
            a_we_q      <= 1'b0;
            b_en_q      <= 1'b0;
            b_we_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            if (pop) begin
                state_q <= ISSUE;
                rd_q    <= head_op == OP_RD;
                port_q  <= head_port;
                if (head_op == OP_WR || head_op == OP_RD) begin
                    if (head_port) begin
                        b_en_q   <= 1'b1;
                        b_we_q   <= head_op == OP_WR;
                        b_addr_q <= head_addr;
                        if (head_op == OP_WR) b_wdata_q <= head_wdata;
                    end else begin
                        a_en_q   <= 1'b1;
                        a_we_q   <= head_op == OP_WR;
                        a_addr_q <= head_addr;
                        if (head_op == OP_WR) a_wdata_q <= head_wdata;
                    end
                end
            end else if (state_q == ISSUE && rd_q) begin
                state_q     <= RD_WAIT;
                cnt_q       <= LAT;
                rsp_valid_q <= LAT == 2'd1;
            end else if (state_q == RD_WAIT && cnt_q != 2'd1) begin
                cnt_q       <= cnt_q - 2'd1;
                rsp_valid_q <= cnt_q == 2'd2;
            end else begin
                state_q <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_hamming_dp_cmd_issuer.sv
// tb_hamming_dp_cmd_issuer: scoreboard bench with a latency-accurate dual-port memory model
module tb_hamming_dp_cmd_issuer;
    localparam int RD_LAT = 2;

    typedef struct packed {
        logic       port;
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
    } strb_t;

    typedef struct packed {
        logic       port;
        logic [7:0] data;
    } rsp_t;

    logic  clk = 1'b0;
    logic  rst_n;
    int    checks = 0;
    int    fails = 0;
    int    cyc = 0;
    int    rd_cyc = 0;
    bit    stall_seen = 1'b0;
    strb_t exp_s[$];
    rsp_t  exp_r[$];
    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    logic [7:0] pa [RD_LAT];
    logic [7:0] pb [RD_LAT];

    hamming_dp_cmd_issuer_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    hamming_dp_cmd_issuer #(.ADDR_W(4), .DATA_W(8), .DEPTH(4), .RD_LAT(RD_LAT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Memory model: writes land on the edge, read data emerges RD_LAT cycles after the strobe
    always @(posedge clk) begin
        if (bus.a_en && bus.a_we) mem_a[bus.a_addr] <= bus.a_wdata;
        if (bus.b_en && bus.b_we) mem_b[bus.b_addr] <= bus.b_wdata;
        pa[0] <= mem_a[bus.a_addr];
        pb[0] <= mem_b[bus.b_addr];
        for (int i = 1; i < RD_LAT; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
        end
    end

    assign bus.a_rdata = pa[RD_LAT-1];
    assign bus.b_rdata = pb[RD_LAT-1];

    // Monitor: compare every strobe and response against the scoreboard queues
    always @(negedge clk) begin
        strb_t e, g;
        rsp_t  r;
        if (rst_n) begin
            if (bus.cmd_valid && !bus.cmd_ready) stall_seen = 1'b1;
            if (bus.a_en || bus.b_en) begin
                checks++;
                g = bus.b_en ? strb_t'{1'b1, bus.b_we, bus.b_addr, bus.b_wdata}
                             : strb_t'{1'b0, bus.a_we, bus.a_addr, bus.a_wdata};
                if (bus.a_en && bus.b_en) begin
                    fails++;
                    $display("FAIL dual_strobe both ports strobed at cycle %0d", cyc);
                end else if (exp_s.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_strobe got=%h at cycle %0d", g, cyc);
                end else begin
                    e = exp_s.pop_front();
                    if (!g.we) rd_cyc = cyc;
                    if (g.port !== e.port || g.we !== e.we || g.addr !== e.addr ||
                        (e.we && g.data !== e.data)) begin
                        fails++;
                        $display("FAIL strobe got port=%0d we=%0d addr=%0h data=%0h exp port=%0d we=%0d addr=%0h data=%0h",
                                 g.port, g.we, g.addr, g.data, e.port, e.we, e.addr, e.data);
                    end
                end
            end
            if (bus.rsp_valid) begin
                checks++;
                if (exp_r.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_rsp port=%0d data=%0h at cycle %0d", bus.rsp_port, bus.rsp_data, cyc);
                end else begin
                    r = exp_r.pop_front();
                    if (bus.rsp_port !== r.port || bus.rsp_data !== r.data || cyc - rd_cyc != RD_LAT) begin
                        fails++;
                        $display("FAIL rsp got port=%0d data=%0h lat=%0d exp port=%0d data=%0h lat=%0d",
                                 bus.rsp_port, bus.rsp_data, cyc - rd_cyc, r.port, r.data, RD_LAT);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic send(input logic p, input logic [1:0] op, input logic [3:0] a, input logic [7:0] d,
                        input bit keep, input logic [7:0] rd);
        int n = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_port  = p;
        bus.cmd_op    = op;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            fails++;
            $display("FAIL send_timeout cmd_ready stuck at 0");
        end
        if (op == 2'd0 || op == 2'd1) exp_s.push_back(strb_t'{p, op == 2'd0, a, d});
        if (op == 2'd1 && keep) exp_r.push_back(rsp_t'{p, rd});
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_s.size() != 0 || exp_r.size() != 0 || bus.busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 32'(n < 200), 32'd1);
    endtask

    initial begin
        int n;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_port  = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_strobes", 32'({bus.a_en, bus.b_en, bus.rsp_valid}), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_illegal", 32'(bus.illegal_op), 32'd0);
        chk("rst_addr", 32'({bus.a_addr, bus.b_addr, bus.a_wdata, bus.b_wdata}), 32'd0);
        rst_n = 1'b1;

        // Write then read on port A, with the two-cycle issue latency checked directly
        send(1'b0, 2'd0, 4'd3, 8'h5A, 1'b0, 8'h00);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("lat_cycle1_idle", 32'(bus.a_en), 32'd0);
        @(negedge clk);
        chk("lat_cycle2_strobe", 32'({bus.a_en, bus.a_we}), 32'd3);
        send(1'b0, 2'd1, 4'd3, 8'h00, 1'b1, 8'h5A);
        idle();
        drain();

        // Write then read on port B; port A outputs must hold their last values
        send(1'b1, 2'd0, 4'd9, 8'hC3, 1'b0, 8'h00);
        send(1'b1, 2'd1, 4'd9, 8'h00, 1'b1, 8'hC3);
        idle();
        drain();
        chk("a_hold", 32'({bus.a_addr, bus.a_wdata}), 32'h35A);

        // Two reads stall the issuer so the following DEPTH+2 writes back up the FIFO
        stall_seen = 1'b0;
        send(1'b1, 2'd1, 4'd9, 8'h00, 1'b1, 8'hC3);
        send(1'b0, 2'd1, 4'd3, 8'h00, 1'b1, 8'h5A);
        for (int i = 0; i < 6; i++) send(i[0], 2'd0, 4'(4 + i), 8'(8'h10 + i), 1'b0, 8'h00);
        idle();
        drain();
        chk("fifo_full_stall", 32'(stall_seen), 32'd1);

        // NONE and illegal op produce no strobes; illegal_op is sticky
        chk("illegal_before", 32'(bus.illegal_op), 32'd0);
        send(1'b0, 2'd2, 4'd1, 8'h11, 1'b0, 8'h00);
        send(1'b1, 2'd3, 4'd2, 8'h22, 1'b0, 8'h00);
        send(1'b0, 2'd0, 4'd0, 8'h77, 1'b0, 8'h00);
        idle();
        drain();
        chk("illegal_set", 32'(bus.illegal_op), 32'd1);
        send(1'b1, 2'd0, 4'd15, 8'hEE, 1'b0, 8'h00);
        idle();
        drain();
        chk("illegal_sticky", 32'(bus.illegal_op), 32'd1);

        // Reset during RD_WAIT drops the pending response
        send(1'b0, 2'd1, 4'd3, 8'h00, 1'b0, 8'h00);
        idle();
        n = 0;
        while (!bus.a_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rd_strobe_seen", 32'(n < 20), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("post_rst_illegal", 32'(bus.illegal_op), 32'd0);

        // Issuer works normally after the reset
        send(1'b1, 2'd1, 4'd15, 8'h00, 1'b1, 8'hEE);
        idle();
        drain();
        chk("queues_empty", 32'(exp_s.size() + exp_r.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
